// File: rtl/se2pa_gen.sv
// Serial-to-parallel packer: LANES complex samples per word, natural or bit-reversed lane order, frame tracking with abort flag.
// Latency: word visible the cycle after its LANES-th accepted sample; no backpressure (DV gaps stall, START always wins).
module se2pa_gen #(
    parameter int NB        = 16,
    parameter int LANES     = 4,
    parameter int FRAME_LEN = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  DV,
    input  logic                  BITREV,
    input  logic [NB-1:0]         DR,
    input  logic [NB-1:0]         DI,
    output logic [NB*LANES-1:0]   OR,
    output logic [NB*LANES-1:0]   OI,
    output logic                  RDY,
    output logic                  LAST,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam int LW    = $clog2(LANES);
    localparam int WORDS = FRAME_LEN / LANES;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [WW-1:0]   word_q, word_d;
    logic            mode_q, mode_d;

    logic [NB-1:0]   hold_r [LANES];
    logic [NB-1:0]   hold_i [LANES];

    logic            accept;
    logic            mode_eff;
    logic [LW-1:0]   k;
    logic [LW-1:0]   slot;
    logic            complete;
    logic            last_word;
    logic            abort;
    logic [NB*LANES-1:0] word_r;
    logic [NB*LANES-1:0] word_i;

    function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] x);
        logic [LW-1:0] y;
        for (int b = 0; b < LW; b++) begin
            y[b] = x[LW-1-b];
        end
        return y;
    endfunction

    // Datapath qualifiers; a START cycle always begins at lane 0 with the freshly sampled mode.
    always_comb begin
        accept    = DV && ((state_q == ACTIVE) || START);
        k         = START ? '0 : lane_q;
        mode_eff  = START ? BITREV : mode_q;
        slot      = mode_eff ? bitrev(k) : k;
        complete  = accept && (k == LW'(LANES - 1));
        last_word = complete && (word_q == WW'(WORDS - 1));
        abort     = START && (state_q == ACTIVE) && ((lane_q != '0) || (word_q != '0));
    end

    // Completed word: holding registers with the final sample merged straight in; slot 0 is the MSB lane.
    always_comb begin
        word_r = '0;
        word_i = '0;
        for (int s = 0; s < LANES; s++) begin
            if (slot == LW'(s)) begin
                word_r[NB*(LANES-s)-1 -: NB] = DR;
                word_i[NB*(LANES-s)-1 -: NB] = DI;
            end else begin
                word_r[NB*(LANES-s)-1 -: NB] = hold_r[s];
                word_i[NB*(LANES-s)-1 -: NB] = hold_i[s];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        mode_d  = mode_q;
        BUSY    = (state_q == ACTIVE);
        if (START) begin
            state_d = ACTIVE;
            mode_d  = BITREV;
            word_d  = '0;
            lane_d  = accept ? LW'(1) : '0;
        end else if (accept) begin
            lane_d = lane_q + LW'(1);
            if (complete) begin
                word_d = word_q + WW'(1);
            end
            if (last_word) begin
                state_d = IDLE;
                word_d  = '0;
                lane_d  = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            lane_q  <= '0;
            word_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < LANES; s++) begin
                hold_r[s] <= '0;
                hold_i[s] <= '0;
            end
        end else if (accept && !complete) begin
            hold_r[slot] <= DR;
            hold_i[slot] <= DI;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OR   <= '0;
            OI   <= '0;
            RDY  <= 1'b0;
            LAST <= 1'b0;
            ERR  <= 1'b0;
        end else begin
            RDY  <= complete;
            LAST <= last_word;
            ERR  <= abort;
            if (complete) begin
                OR <= word_r;
                OI <= word_i;
            end
        end
    end

endmodule
